// File: rtl/read_miss_queue_if.sv
// read_miss_queue_if: miss, CXL read-request and retire signals of the read-miss address queue.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
interface read_miss_queue_if #(
  parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int PTR_W = 4
);
  logic miss_valid_i;
  logic miss_ready_o;
  logic [ADDR_WIDTH-1:0] miss_addr_i;
  logic cxl_arvalid_o;
  logic cxl_arready_i;
  logic [ADDR_WIDTH-1:0] cxl_araddr_o;
  logic read_en_i;
  logic empty_o;
  logic [ADDR_WIDTH-1:0] ar_o;
  logic [PTR_W-1:0] inflight_o;
  logic [PTR_W-1:0] count_o;
  logic err_o;
  modport master (
    output miss_valid_i, miss_addr_i, cxl_arready_i, read_en_i,
    input miss_ready_o, cxl_arvalid_o, cxl_araddr_o, empty_o, ar_o, inflight_o, count_o, err_o
  );
  modport slave (
    input miss_valid_i, miss_addr_i, cxl_arready_i, read_en_i,
    output miss_ready_o, cxl_arvalid_o, cxl_araddr_o, empty_o, ar_o, inflight_o, count_o, err_o
  );
endinterface

// File: rtl/read_miss_queue.sv
// read_miss_queue: circular buffer with write/issue/retire pointers so CXL request order equals data-return order.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
module read_miss_queue #(
  parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  read_miss_queue_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr, iss, rd, count;
  logic ready, arvalid, empty, err, push, issue, retire;
  assign count = wr - rd;
  assign ready = count != PTR_W'(DEPTH);
  assign arvalid = iss != wr;
  assign empty = rd == iss;
  assign push = bus.miss_valid_i & ready;
  assign issue = arvalid & bus.cxl_arready_i;
  assign retire = bus.read_en_i & ~empty;
  assign bus.miss_ready_o = ready;
  assign bus.cxl_arvalid_o = arvalid;
  assign bus.cxl_araddr_o = mem[iss[IW-1:0]];
  assign bus.empty_o = empty;
  assign bus.ar_o = mem[rd[IW-1:0]];
  assign bus.inflight_o = iss - rd;
  assign bus.count_o = count;
  assign bus.err_o = err;
  // Wrap bit in the pointer MSB separates full (count==DEPTH) from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr <= '0;
      iss <= '0;
      rd <= '0;
      err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr[IW-1:0]] <= bus.miss_addr_i;
        wr <= wr + PTR_W'(1);
      end
      if (issue) iss <= iss + PTR_W'(1);
      if (retire) rd <= rd + PTR_W'(1);
      if (bus.read_en_i & empty) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_read_miss_queue.sv
// tb_read_miss_queue: scoreboard bench; pending-issue and pending-retire queues model the expected outputs.
module tb_read_miss_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  read_miss_queue_if #(.ADDR_WIDTH(32), .PTR_W(4)) bus ();
  read_miss_queue #(.ADDR_WIDTH(32), .DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] iss_q [$];
  logic [31:0] ret_q [$];
  logic err_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_ready", 32'(bus.miss_ready_o), 1);
    chk("rst_arvalid", 32'(bus.cxl_arvalid_o), 0);
    chk("rst_araddr", bus.cxl_araddr_o, 0);
    chk("rst_empty", 32'(bus.empty_o), 1);
    chk("rst_ar", bus.ar_o, 0);
    chk("rst_inflight", 32'(bus.inflight_o), 0);
    chk("rst_count", 32'(bus.count_o), 0);
    chk("rst_err", 32'(bus.err_o), 0);
  endtask

  // One clock cycle: drive, check mid-cycle against the model, advance the model, step the clock.
  task automatic cycle(input logic pv, input logic [31:0] pa, input logic ar, input logic re);
    int total;
    bus.miss_valid_i = pv;
    bus.miss_addr_i = pa;
    bus.cxl_arready_i = ar;
    bus.read_en_i = re;
    #3;
    total = iss_q.size() + ret_q.size();
    chk("count", 32'(bus.count_o), 32'(total));
    chk("inflight", 32'(bus.inflight_o), 32'(ret_q.size()));
    chk("ready", 32'(bus.miss_ready_o), 32'(total != 8));
    chk("arvalid", 32'(bus.cxl_arvalid_o), 32'(iss_q.size() != 0));
    chk("empty", 32'(bus.empty_o), 32'(ret_q.size() == 0));
    chk("err", 32'(bus.err_o), 32'(err_m));
    if (iss_q.size() > 0) chk("araddr", bus.cxl_araddr_o, iss_q[0]);
    if (ret_q.size() > 0) chk("ar", bus.ar_o, ret_q[0]);
    if (re) begin
      if (ret_q.size() > 0) void'(ret_q.pop_front());
      else err_m = 1'b1;
    end
    if (ar && iss_q.size() > 0) ret_q.push_back(iss_q.pop_front());
    if (pv && total != 8) iss_q.push_back(pa);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.miss_valid_i = 1'b0;
    bus.miss_addr_i = '0;
    bus.cxl_arready_i = 1'b0;
    bus.read_en_i = 1'b0;
    #12;
    chk_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    // single miss: issued in cycle 1, visible on ar in cycle 2, retired in cycle 4
    cycle(1, 32'h1000, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    // ordering under backpressure
    cycle(1, 32'h100, 0, 0);
    cycle(1, 32'h200, 0, 0);
    cycle(1, 32'h300, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 0);
    end
    // full: ninth miss held, retire does not admit a push in the same cycle
    for (int i = 0; i < 8; i++) cycle(1, 32'h40 + 32'(i), 0, 0);
    cycle(1, 32'hdead, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 32'hbeef, 0, 1);
    cycle(1, 32'hbeef, 0, 0);
    for (int i = 0; i < 40 && (iss_q.size() + ret_q.size()) > 0; i++)
      cycle(0, 0, 1, ret_q.size() > 0);
    chk("full_drained", 32'(iss_q.size() + ret_q.size()), 0);
    // wrap-around with sustained push/issue/retire
    for (int i = 0; i < 24; i++) begin
      cycle(i < 20, 32'h2000 + 32'(i), 1, ret_q.size() > 0);
      chk("wrap_inflight_le1", 32'(bus.inflight_o <= 1), 1);
    end
    cycle(0, 0, 0, 0);
    chk("wrap_drained", 32'(iss_q.size() + ret_q.size()), 0);
    // illegal retire sets sticky error
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 32'h77, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    // asynchronous reset mid-cycle discards queued and issued entries
    cycle(1, 32'h5, 0, 0);
    cycle(1, 32'h6, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset();
    iss_q.delete();
    ret_q.delete();
    err_m = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(0, 0, 1, 0);
    cycle(1, 32'h9, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
